// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-Lite types and constants for the miniTB pipelined master.
package minitb_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    DP_NONE   = 2'd0,
    DP_ACTIVE = 2'd1,
    DP_ERR    = 2'd2
  } dp_state_t;

  // Command layout at the default 8-bit address / 32-bit data widths.
  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;

  typedef struct packed {
    logic                  write;
    logic [2:0]            size;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } ahb_cmd_t;

endpackage

// File: rtl/minitb_sync_fifo.sv
// Synchronous FIFO with head and next-after-head peek ports.
module minitb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         head_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/minitb_ahb_pipelined_master.sv
// AHB-Lite master: queued commands issued as pipelined NONSEQ transfers
// with wait-state and two-cycle ERROR handling, one in-order response each.
module minitb_ahb_pipelined_master
  import minitb_ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [1:0]            htrans,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  localparam int CW = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic                  write;
    logic [2:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  cmd_t      cmd_in_s, head_s, head_next_s, next_cmd_s;
  logic      full_s, empty_s, push_s, accept_s;
  logic [CW:0] count_s;
  logic      complete_s, error_s, more_s;
  dp_state_t dp_state_r, dp_next_s;
  logic      dp_write_r;

  assign cmd_in_s  = {cmd_write, cmd_size, cmd_addr, cmd_wdata};
  assign cmd_ready = !full_s;
  assign push_s    = cmd_valid && cmd_ready;
  assign accept_s  = (htrans == HTRANS_NONSEQ) && hready;

  minitb_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (hclk),
    .reset     (hreset),
    .push      (push_s),
    .push_data (cmd_in_s),
    .pop       (accept_s),
    .head      (head_s),
    .head_next (head_next_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Data-phase outcome and the command that owns the next address phase.
  always_comb begin
    complete_s = 1'b0;
    error_s    = 1'b0;
    dp_next_s  = dp_state_r;
    case (dp_state_r)
      DP_ACTIVE: begin
        if (hready) begin
          complete_s = 1'b1;
          error_s    = (hresp == HRESP_ERROR);
          dp_next_s  = DP_NONE;
        end else if (hresp == HRESP_ERROR) begin
          dp_next_s  = DP_ERR;
        end else begin
          dp_next_s  = DP_ACTIVE;
        end
      end
      DP_ERR: begin
        if (hready) begin
          complete_s = 1'b1;
          error_s    = 1'b1;
          dp_next_s  = DP_NONE;
        end else begin
          dp_next_s  = DP_ERR;
        end
      end
      default: dp_next_s = DP_NONE;
    endcase
    if (accept_s) dp_next_s = DP_ACTIVE;
    more_s     = accept_s ? (count_s > (CW+1)'(1)) : !empty_s;
    next_cmd_s = accept_s ? head_next_s : head_s;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dp_state_r <= DP_NONE;
      dp_write_r <= 1'b0;
      htrans     <= HTRANS_IDLE;
      haddr      <= '0;
      hwrite     <= 1'b0;
      hsize      <= 3'd0;
      hwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
    end else begin
      dp_state_r <= dp_next_s;
      if (accept_s) begin
        dp_write_r <= head_s.write;
        hwdata     <= head_s.write ? head_s.wdata : '0;
      end else if (complete_s) begin
        hwdata     <= '0;
      end
      rsp_valid <= complete_s;
      rsp_write <= complete_s && dp_write_r;
      rsp_error <= error_s;
      rsp_rdata <= (complete_s && !error_s && !dp_write_r) ? hrdata : '0;
      // An errored data phase cancels any pending address phase; a stalled one holds it.
      if (dp_next_s == DP_ERR) begin
        htrans <= HTRANS_IDLE;
      end else if ((htrans == HTRANS_NONSEQ) && !hready) begin
        htrans <= htrans;
      end else if (more_s) begin
        htrans <= HTRANS_NONSEQ;
        haddr  <= next_cmd_s.addr;
        hwrite <= next_cmd_s.write;
        hsize  <= next_cmd_s.size;
      end else begin
        htrans <= HTRANS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_minitb_ahb_pipelined_master.sv
// Self-checking bench: queue-level model of the master plus directed literal checks and random traffic.
module tb_minitb_ahb_pipelined_master;
  import minitb_ahb_pkg::*;

  logic        hclk;
  logic        hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;
  logic        rsp_valid, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;

  minitb_ahb_pipelined_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CMD_DEPTH(4)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct packed {
    logic        w;
    logic [2:0]  sz;
    logic [7:0]  a;
    logic [31:0] d;
  } mcmd_t;

  // Model state: pending commands, data-phase occupant, expected outputs.
  mcmd_t       q[$];
  mcmd_t       dp_cmd;
  int          dp;
  bit          e_ns;
  logic [7:0]  e_addr;
  logic        e_write;
  logic [2:0]  e_size;
  logic [31:0] e_hwdata;
  bit          e_rv, e_rw, e_re;
  logic [31:0] e_rd;

  int          checks = 0;
  int          failures = 0;
  int          rv_seen = 0;
  logic [31:0] got_rd[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_edge();
    mcmd_t pc;
    bit push, accept, complete, err;
    int ndp;
    if (hreset) begin
      q.delete();
      dp = 0; e_ns = 0; e_addr = '0; e_write = 0; e_size = '0; e_hwdata = '0;
      e_rv = 0; e_rw = 0; e_re = 0; e_rd = '0;
    end else begin
      push  = cmd_valid && (q.size() < 4);
      pc.w  = cmd_write; pc.sz = cmd_size; pc.a = cmd_addr; pc.d = cmd_wdata;
      accept = e_ns && hready;
      complete = 0; err = 0; ndp = dp;
      if (dp == 1) begin
        if (hready) begin complete = 1; err = hresp; ndp = 0; end
        else if (hresp) ndp = 2;
      end else if (dp == 2) begin
        if (hready) begin complete = 1; err = 1; ndp = 0; end
      end
      e_rv = complete;
      e_rw = complete && dp_cmd.w;
      e_re = err;
      e_rd = (complete && !err && !dp_cmd.w) ? hrdata : 32'h0;
      if (accept) begin
        dp_cmd = q.pop_front();
        ndp = 1;
        e_hwdata = dp_cmd.w ? dp_cmd.d : 32'h0;
      end else if (complete) begin
        e_hwdata = 32'h0;
      end
      if (ndp == 2) begin
        e_ns = 0;
      end else if (!(e_ns && !hready)) begin
        if (q.size() > 0) begin
          e_ns = 1; e_addr = q[0].a; e_write = q[0].w; e_size = q[0].sz;
        end else begin
          e_ns = 0;
        end
      end
      dp = ndp;
      if (push) q.push_back(pc);
    end
  endtask

  task automatic compare_all();
    chk("htrans", {62'b0, htrans}, e_ns ? 64'h2 : 64'h0);
    chk("haddr", {56'b0, haddr}, {56'b0, e_addr});
    chk("hwrite", {63'b0, hwrite}, {63'b0, e_write});
    chk("hsize", {61'b0, hsize}, {61'b0, e_size});
    chk("hwdata", {32'b0, hwdata}, {32'b0, e_hwdata});
    chk("cmd_ready", {63'b0, cmd_ready}, (q.size() < 4) ? 64'h1 : 64'h0);
    chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, e_rv});
    if (e_rv) begin
      chk("rsp_write", {63'b0, rsp_write}, {63'b0, e_rw});
      chk("rsp_error", {63'b0, rsp_error}, {63'b0, e_re});
      chk("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e_rd});
    end
    if (rsp_valid === 1'b1) begin
      rv_seen++;
      if (rsp_write === 1'b0) got_rd.push_back(rsp_rdata);
    end
  endtask

  task automatic step(input bit v, input bit w, input logic [7:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input bit rdy, input bit er,
                      input logic [31:0] rd, input bit rst);
    hreset = rst; cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    hready = rdy; hresp = er; hrdata = rd;
    model_edge();
    @(posedge hclk);
    @(negedge hclk);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, rdy, 1'b0, $urandom, 1'b0);
  endtask

  int rv_mark;

  initial begin
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
    cmd_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    @(negedge hclk);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_htrans", {62'b0, htrans}, 64'h0);
    chk("rst_hwdata", {32'b0, hwdata}, 64'h0);
    chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'h0);
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'h1);

    // Single write
    step(1'b1, 1'b1, 8'h10, HSIZE_WORD, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("sw_idle0", {62'b0, htrans}, 64'h0);
    idle(1'b1);
    chk("sw_nonseq", {62'b0, htrans}, 64'h2);
    chk("sw_haddr", {56'b0, haddr}, 64'h10);
    chk("sw_hwrite", {63'b0, hwrite}, 64'h1);
    idle(1'b1);
    chk("sw_hwdata", {32'b0, hwdata}, 64'hDEADBEEF);
    idle(1'b1);
    chk("sw_rsp_valid", {63'b0, rsp_valid}, 64'h1);
    chk("sw_rsp_error", {63'b0, rsp_error}, 64'h0);
    idle(1'b1); idle(1'b1);

    // Pipelined reads
    got_rd.delete();
    step(1'b1, 1'b0, 8'h00, HSIZE_WORD, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 8'h04, HSIZE_WORD, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("pr_nonseq0", {56'b0, haddr}, 64'h00);
    step(1'b1, 1'b0, 8'h08, HSIZE_WORD, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("pr_nonseq1", {56'b0, haddr}, 64'h04);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b0, 32'h11, 1'b0);
    chk("pr_nonseq2", {56'b0, haddr}, 64'h08);
    chk("pr_htrans2", {62'b0, htrans}, 64'h2);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b0, 32'h22, 1'b0);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b0, 32'h33, 1'b0);
    chk("pr_count", 64'(got_rd.size()), 64'd3);
    if (got_rd.size() == 3) begin
      chk("pr_rd0", {32'b0, got_rd[0]}, 64'h11);
      chk("pr_rd1", {32'b0, got_rd[1]}, 64'h22);
      chk("pr_rd2", {32'b0, got_rd[2]}, 64'h33);
    end
    idle(1'b1); idle(1'b1);

    // Wait states
    step(1'b1, 1'b1, 8'h20, HSIZE_WORD, 32'hCAFE0001, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 8'h24, HSIZE_WORD, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("ws_haddr_a", {56'b0, haddr}, 64'h24);
    chk("ws_hwdata_a", {32'b0, hwdata}, 64'hCAFE0001);
    idle(1'b0);
    chk("ws_haddr_b", {56'b0, haddr}, 64'h24);
    chk("ws_htrans_b", {62'b0, htrans}, 64'h2);
    chk("ws_hwdata_b", {32'b0, hwdata}, 64'hCAFE0001);
    idle(1'b1);
    chk("ws_wr_rsp", {62'b0, rsp_valid, rsp_write}, 64'h3);
    chk("ws_rd_accepted", {62'b0, htrans}, 64'h0);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b0, 32'h5A5A, 1'b0);
    chk("ws_rd_rdata", {32'b0, rsp_rdata}, 64'h5A5A);
    idle(1'b1);

    // Error cancel
    step(1'b1, 1'b0, 8'h30, HSIZE_WORD, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 8'h34, HSIZE_WORD, 32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    chk("er_idle", {62'b0, htrans}, 64'h0);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b1, 1'b1, 32'hFFFF, 1'b0);
    chk("er_rsp_error", {62'b0, rsp_valid, rsp_error}, 64'h3);
    chk("er_rsp_rdata", {32'b0, rsp_rdata}, 64'h0);
    chk("er_reissue", {54'b0, htrans, haddr}, 64'h234);
    idle(1'b1);
    chk("er_wdata", {32'b0, hwdata}, 64'h12345678);
    idle(1'b1);
    chk("er_wr_ok", {61'b0, rsp_valid, rsp_write, rsp_error}, 64'h6);
    idle(1'b1);

    // FIFO full
    for (int i = 0; i < 4; i++)
      step(1'b1, i[0], 8'h40 + 8'(4 * i), HSIZE_WORD, 32'hA0 + 32'(i), 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ff_full", {63'b0, cmd_ready}, 64'h0);
    step(1'b1, 1'b1, 8'h50, HSIZE_WORD, 32'hBAD, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("ff_still_full", {63'b0, cmd_ready}, 64'h0);
    idle(1'b1);
    chk("ff_ready_again", {63'b0, cmd_ready}, 64'h1);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Reset mid-transfer
    step(1'b1, 1'b1, 8'h60, HSIZE_WORD, 32'h60, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 8'h64, HSIZE_WORD, 32'h64, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 8'h68, HSIZE_WORD, 32'h68, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rm_htrans", {62'b0, htrans}, 64'h0);
    chk("rm_hwdata", {32'b0, hwdata}, 64'h0);
    chk("rm_cmd_ready", {63'b0, cmd_ready}, 64'h1);
    rv_mark = rv_seen;
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("rm_no_rsp", 64'(rv_seen - rv_mark), 64'd0);

    // Random traffic with a randomly behaving slave
    for (int c = 0; c < 3000; c++) begin
      bit rdy, er, v, rst;
      int r;
      r = $urandom_range(0, 99);
      if (dp == 2) begin
        rdy = 1'b1; er = 1'b1;
      end else if (dp == 1) begin
        if (r < 8)       begin rdy = 1'b0; er = 1'b1; end
        else if (r < 10) begin rdy = 1'b1; er = 1'b1; end
        else             begin rdy = (r < 70); er = 1'b0; end
      end else begin
        rdy = (r % 4) != 0; er = 1'b0;
      end
      v   = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 499) == 0;
      step(v, $urandom_range(0, 1) == 1, 8'($urandom), 3'($urandom_range(0, 2)),
           $urandom, rdy, er, $urandom, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
